instr_decoder: RTL and testbench
================================

INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the width of imm_o (at least 13).
REQ-002 The block SHALL have parameter SEXT, default 1: 1 means imm_o is the sign-extended offset, 0 means it is zero-extended.
REQ-003 The block SHALL have port clk_i, input, 1 bit, as its single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port instr_i, input, 32 bits: the instruction word, laid out as offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0].
REQ-006 The block SHALL have port instr_valid_i, input, 1 bit: instr_i holds a valid instruction.
REQ-007 The block SHALL have port instr_ready_o, output, 1 bit: the decoder accepts instr_i this cycle.
REQ-008 The block SHALL have port flush_i, input, 1 bit: discard the held output and leave HALT.
REQ-009 The block SHALL have port dec_valid_o, output, 1 bit: the decoded outputs are valid.
REQ-010 The block SHALL have port dec_ready_i, input, 1 bit: the consumer takes the decoded outputs.
REQ-011 The block SHALL have ports opcode_o (4 bits), ra_o, rb_o and wb_reg_o (5 bits each), all outputs: the decoded fields and the write-back register index.
REQ-012 The block SHALL have port imm_o, output, DATAWIDTH bits: the extended offset.
REQ-013 The block SHALL have 1-bit output flags is_alu_o, is_load_o, is_store_o, is_branch_o, is_jump_o, is_li_o, reg_write_o and illegal_o.
REQ-014 The block SHALL have output instr_count_o (32 bits) and output illegal_count_o (16 bits).

Function
REQ-015 Opcode map SHALL be: ADD=0, LW=1, SW=2, SUB=3, MUL=4, DIV=5, AND=6, OR=7, XOR=8, BEQ=9, BGT=10, BGE=11, JMP=12, LI=13; opcodes 14 and 15 are illegal.
REQ-016 The ALU class SHALL be opcodes {0,3,4,5,6,7,8}, and is_branch_o SHALL be asserted for {9,10,11}.
REQ-017 wb_reg_o SHALL be: rd for ALU and LI; rb for LW; 0 for all other opcodes.
REQ-018 reg_write_o SHALL be 1 exactly for ALU, LW and LI.
REQ-019 Every decoded output SHALL be registered, giving a latency of 1 cycle from acceptance to dec_valid_o=1.
REQ-020 An instruction SHALL be accepted when instr_valid_i && instr_ready_o.
REQ-021 instr_ready_o SHALL be state==RUN && !flush_i && (!dec_valid_o || dec_ready_i), which allows back-to-back throughput of one instruction per cycle.
REQ-022 While dec_valid_o=1 && dec_ready_i=0, all decoded outputs SHALL hold stable.
REQ-023 dec_valid_o SHALL drop to 0 after a handshake in which no new instruction is accepted.
REQ-024 The FSM SHALL have states RUN and HALT.
REQ-025 Accepting an illegal opcode SHALL move the FSM RUN->HALT; the illegal instruction is still presented with illegal_o=1 and all class flags 0.
REQ-026 In HALT, instr_ready_o SHALL be 0.
REQ-027 flush_i=1 SHALL, on the next edge, clear dec_valid_o and set the state to RUN, taking priority over a pending output handshake.
REQ-028 A flushed entry SHALL NOT be counted as consumed; counters are unaffected by flush.
REQ-029 instr_count_o SHALL increment on every accepted instruction, legal or illegal, and saturate at 0xFFFFFFFF.
REQ-030 illegal_count_o SHALL increment on every accepted illegal instruction and saturate at 0xFFFF.
REQ-031 imm_o SHALL be offset[12] replicated (SEXT=1) or zeros (SEXT=0) concatenated with offset[12:0].

Reset
REQ-032 While rst_i=1, the block SHALL immediately drive dec_valid_o=0, all decoded fields and flags 0, both counters 0 and state RUN, independent of clk_i.
REQ-033 After rst_i deasserts, instr_ready_o SHALL be 1 in the first cycle.
REQ-034 Reset mid-handshake SHALL discard the held entry without counting it.

Verification
REQ-035 The bench SHALL drive instr_i=0x00004230 (ADD, ra=1, rb=1, rd=3) with valid=1 and ready=1, and check that 1 cycle later dec_valid_o=1, opcode_o=0, ra_o=1, rb_o=1, wb_reg_o=3, is_alu_o=1, reg_write_o=1 and instr_count_o=1.
REQ-036 The bench SHALL drive LW 0x00780801 (offset=15, ra=0, rb=4) and check imm_o=0x0000000F, is_load_o=1 and wb_reg_o=4; it SHALL then drive SW 0x00780E02 and check is_store_o=1, reg_write_o=0 and wb_reg_o=0.
REQ-037 The bench SHALL drive LI 0xFFF8002D (offset=0x1FFF, rd=2) with SEXT=1 and check imm_o=0xFFFFFFFF and wb_reg_o=2; with SEXT=0 it SHALL check imm_o=0x00001FFF.
REQ-038 The bench SHALL hold dec_ready_i=0 for 3 cycles while streaming the twelve test instructions, and check that the outputs stay stable, instr_ready_o=0, no instruction is lost or duplicated, and instr_count_o=12 at the end.
REQ-039 The bench SHALL drive 0x0000000E and check illegal_o=1, illegal_count_o=1, and instr_ready_o=0 while further instructions are offered; it SHALL then pulse flush_i for 1 cycle and check dec_valid_o=0, state RUN and instr_ready_o=1 on the next cycle.
REQ-040 The bench SHALL assert rst_i asynchronously between clock edges while dec_valid_o=1, and check that dec_valid_o and both counters go to 0 before the next rising edge.

Source files
------------

// File: rtl/instr_decoder.sv
// Single-issue instruction decoder: a one-entry registered output stage with a
// valid/ready handshake, a RUN/HALT FSM that stops on illegal opcodes, and saturating counters.
module instr_decoder #(
  parameter int DATAWIDTH = 32,
  parameter bit SEXT      = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic                 flush_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [3:0]           opcode_o,
  output logic [4:0]           ra_o,
  output logic [4:0]           rb_o,
  output logic [4:0]           wb_reg_o,
  output logic [DATAWIDTH-1:0] imm_o,
  output logic                 is_alu_o,
  output logic                 is_load_o,
  output logic                 is_store_o,
  output logic                 is_branch_o,
  output logic                 is_jump_o,
  output logic                 is_li_o,
  output logic                 reg_write_o,
  output logic                 illegal_o,
  output logic [31:0]          instr_count_o,
  output logic [15:0]          illegal_count_o
);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_LW  = 4'd1,  OP_SW  = 4'd2,  OP_SUB = 4'd3,
                         OP_MUL = 4'd4,  OP_DIV = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7,
                         OP_XOR = 4'd8,  OP_BEQ = 4'd9,  OP_BGT = 4'd10, OP_BGE = 4'd11,
                         OP_JMP = 4'd12, OP_LI  = 4'd13;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [4:0]           ra;
    logic [4:0]           rb;
    logic [4:0]           wb_reg;
    logic [DATAWIDTH-1:0] imm;
    logic                 is_alu;
    logic                 is_load;
    logic                 is_store;
    logic                 is_branch;
    logic                 is_jump;
    logic                 is_li;
    logic                 reg_write;
    logic                 illegal;
  } dec_t;

  state_t state_q, state_d;
  dec_t   dec_d, dec_q;
  logic   accept;

  assign instr_ready_o = (state_q == RUN) && !flush_i && (!dec_valid_o || dec_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    dec_d           = '0;
    dec_d.opcode    = instr_i[3:0];
    dec_d.ra        = instr_i[18:14];
    dec_d.rb        = instr_i[13:9];
    // Fill the upper bits first, then overlay the 13-bit offset.
    dec_d.imm       = (SEXT && instr_i[31]) ? '1 : '0;
    dec_d.imm[12:0] = instr_i[31:19];
    case (instr_i[3:0])
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
        dec_d.is_alu    = 1'b1;
        dec_d.reg_write = 1'b1;
        dec_d.wb_reg    = instr_i[8:4];
      end
      OP_LW: begin
        dec_d.is_load   = 1'b1;
        dec_d.reg_write = 1'b1;
        dec_d.wb_reg    = instr_i[13:9];
      end
      OP_SW:                  dec_d.is_store  = 1'b1;
      OP_BEQ, OP_BGT, OP_BGE: dec_d.is_branch = 1'b1;
      OP_JMP:                 dec_d.is_jump   = 1'b1;
      OP_LI: begin
        dec_d.is_li     = 1'b1;
        dec_d.reg_write = 1'b1;
        dec_d.wb_reg    = instr_i[8:4];
      end
      default:                dec_d.illegal   = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush_i)                        state_d = RUN;
    else if (accept && dec_d.illegal)   state_d = HALT;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Flush wins over both a new acceptance (already masked by ready) and a pending handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_valid_o     <= 1'b0;
      dec_q           <= '0;
      instr_count_o   <= '0;
      illegal_count_o <= '0;
    end else if (flush_i) begin
      dec_valid_o <= 1'b0;
    end else if (accept) begin
      dec_valid_o <= 1'b1;
      dec_q       <= dec_d;
      if (instr_count_o != '1) instr_count_o <= instr_count_o + 32'd1;
      if (dec_d.illegal && illegal_count_o != '1) illegal_count_o <= illegal_count_o + 16'd1;
    end else if (dec_valid_o && dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end

  assign opcode_o    = dec_q.opcode;
  assign ra_o        = dec_q.ra;
  assign rb_o        = dec_q.rb;
  assign wb_reg_o    = dec_q.wb_reg;
  assign imm_o       = dec_q.imm;
  assign is_alu_o    = dec_q.is_alu;
  assign is_load_o   = dec_q.is_load;
  assign is_store_o  = dec_q.is_store;
  assign is_branch_o = dec_q.is_branch;
  assign is_jump_o   = dec_q.is_jump;
  assign is_li_o     = dec_q.is_li;
  assign reg_write_o = dec_q.reg_write;
  assign illegal_o   = dec_q.illegal;
endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: a sign-extending and a zero-extending instance share stimulus
// and are checked against a transaction-level scoreboard plus directed scenarios.
module tb_instr_decoder;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0, flush_i = 1'b0, dec_ready_i = 1'b0;

  logic        instr_ready_o, dec_valid_o;
  logic [3:0]  opcode_o;
  logic [4:0]  ra_o, rb_o, wb_reg_o;
  logic [31:0] imm_o, instr_count_o;
  logic [15:0] illegal_count_o;
  logic        is_alu_o, is_load_o, is_store_o, is_branch_o, is_jump_o, is_li_o, reg_write_o, illegal_o;

  logic        z_ready, z_valid;
  logic [3:0]  z_opcode;
  logic [4:0]  z_ra, z_rb, z_wb;
  logic [31:0] z_imm, z_cnt;
  logic [15:0] z_ill_cnt;
  logic        z_alu, z_ld, z_st, z_br, z_jmp, z_li, z_rw, z_ill;

  always #5 clk_i = ~clk_i;

  instr_decoder #(.DATAWIDTH(32), .SEXT(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .flush_i(flush_i), .dec_valid_o(dec_valid_o),
    .dec_ready_i(dec_ready_i), .opcode_o(opcode_o), .ra_o(ra_o), .rb_o(rb_o),
    .wb_reg_o(wb_reg_o), .imm_o(imm_o), .is_alu_o(is_alu_o), .is_load_o(is_load_o),
    .is_store_o(is_store_o), .is_branch_o(is_branch_o), .is_jump_o(is_jump_o),
    .is_li_o(is_li_o), .reg_write_o(reg_write_o), .illegal_o(illegal_o),
    .instr_count_o(instr_count_o), .illegal_count_o(illegal_count_o));

  instr_decoder #(.DATAWIDTH(32), .SEXT(1'b0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(z_ready), .flush_i(flush_i), .dec_valid_o(z_valid),
    .dec_ready_i(dec_ready_i), .opcode_o(z_opcode), .ra_o(z_ra), .rb_o(z_rb),
    .wb_reg_o(z_wb), .imm_o(z_imm), .is_alu_o(z_alu), .is_load_o(z_ld),
    .is_store_o(z_st), .is_branch_o(z_br), .is_jump_o(z_jmp),
    .is_li_o(z_li), .reg_write_o(z_rw), .illegal_o(z_ill),
    .instr_count_o(z_cnt), .illegal_count_o(z_ill_cnt));

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  ra, rb, wb;
    logic [31:0] imm;
    logic        alu, ld, st, br, jmp, li, rw, ill;
  } exp_t;

  int unsigned nvec = 0, nerr = 0, n_consumed = 0;
  logic [31:0] q[$];
  logic        m_halt = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [15:0] m_ill = '0;

  function automatic exp_t ref_dec(input logic [31:0] w, input bit sext);
    exp_t e;
    int   op, off;
    op    = int'(w[3:0]);
    off   = int'(w[31:19]);
    e.op  = w[3:0];
    e.ra  = w[18:14];
    e.rb  = w[13:9];
    e.alu = op inside {0, 3, 4, 5, 6, 7, 8};
    e.ld  = (op == 1);
    e.st  = (op == 2);
    e.br  = op inside {9, 10, 11};
    e.jmp = (op == 12);
    e.li  = (op == 13);
    e.ill = (op > 13);
    e.rw  = e.alu || e.ld || e.li;
    e.wb  = (e.alu || e.li) ? w[8:4] : (e.ld ? w[13:9] : 5'd0);
    e.imm = (sext && off >= 4096) ? 32'(off - 8192) : 32'(off);
    return e;
  endfunction

  function automatic exp_t got1();
    return {opcode_o, ra_o, rb_o, wb_reg_o, imm_o, is_alu_o, is_load_o, is_store_o,
            is_branch_o, is_jump_o, is_li_o, reg_write_o, illegal_o};
  endfunction

  function automatic exp_t got0();
    return {z_opcode, z_ra, z_rb, z_wb, z_imm, z_alu, z_ld, z_st, z_br, z_jmp, z_li, z_rw, z_ill};
  endfunction

  task automatic m_reset();
    q.delete();
    m_halt = 1'b0;
    m_cnt  = '0;
    m_ill  = '0;
  endtask

  task automatic do_reset();
    instr_valid_i = 1'b0; instr_i = '0; dec_ready_i = 1'b0; flush_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_reset();
  endtask

  // One clock of stimulus; the scoreboard checks the cycle, then advances past the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                       output logic acc);
    exp_t e;
    logic er, ev;
    instr_valid_i = v; instr_i = ins; dec_ready_i = rdy; flush_i = fl;
    #1;
    ev = (q.size() != 0);
    er = !m_halt && !fl && (!ev || rdy);
    nvec++;
    if ({dec_valid_o, z_valid} !== {ev, ev}) begin
      nerr++; $display("FAIL dec_valid got=%b/%b exp=%b", dec_valid_o, z_valid, ev);
    end
    nvec++;
    if ({instr_ready_o, z_ready} !== {er, er}) begin
      nerr++; $display("FAIL instr_ready got=%b/%b exp=%b", instr_ready_o, z_ready, er);
    end
    if (ev) begin
      e = ref_dec(q[0], 1'b1);
      nvec++;
      if (got1() !== e) begin
        nerr++; $display("FAIL fields_sext instr=%h got=%h exp=%h", q[0], got1(), e);
      end
      e = ref_dec(q[0], 1'b0);
      nvec++;
      if (got0() !== e) begin
        nerr++; $display("FAIL fields_zext instr=%h got=%h exp=%h", q[0], got0(), e);
      end
    end
    acc = v && er;
    if (fl) begin
      q.delete();
      m_halt = 1'b0;
    end else begin
      if (ev && rdy) begin
        void'(q.pop_front());
        n_consumed++;
      end
      if (acc) begin
        q.push_back(ins);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (ins[3:0] > 4'd13) begin
          if (m_ill != 16'hFFFF) m_ill++;
          m_halt = 1'b1;
        end
      end
    end
    @(posedge clk_i); #1;
    nvec++;
    if ({instr_count_o, illegal_count_o, z_cnt, z_ill_cnt} !== {m_cnt, m_ill, m_cnt, m_ill}) begin
      nerr++; $display("FAIL counters got=%0d/%0d exp=%0d/%0d", instr_count_o, illegal_count_o, m_cnt, m_ill);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    nvec++;
    if ({dec_valid_o, got1(), instr_count_o, illegal_count_o} !== '0) begin
      nerr++; $display("FAIL reset_state valid=%b fields=%h cnt=%0d ill=%0d",
                       dec_valid_o, got1(), instr_count_o, illegal_count_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_reset();
    #1;
    nvec++;
    if (instr_ready_o !== 1'b1) begin
      nerr++; $display("FAIL ready_after_reset got=%b exp=1", instr_ready_o);
    end
  endtask

  task automatic test_add();
    logic acc;
    do_reset();
    cycle(1'b1, 32'h0000_4230, 1'b1, 1'b0, acc);
    nvec++;
    if ({dec_valid_o, opcode_o, ra_o, rb_o, wb_reg_o, is_alu_o, reg_write_o, instr_count_o} !==
        {1'b1, 4'd0, 5'd1, 5'd1, 5'd3, 1'b1, 1'b1, 32'd1}) begin
      nerr++; $display("FAIL add got v=%b op=%0d ra=%0d rb=%0d wb=%0d alu=%b rw=%b cnt=%0d exp 1/0/1/1/3/1/1/1",
                       dec_valid_o, opcode_o, ra_o, rb_o, wb_reg_o, is_alu_o, reg_write_o, instr_count_o);
    end
  endtask

  task automatic test_load_store();
    logic acc;
    cycle(1'b1, 32'h0078_0801, 1'b1, 1'b0, acc);
    nvec++;
    if ({imm_o, is_load_o, wb_reg_o} !== {32'h0000_000F, 1'b1, 5'd4}) begin
      nerr++; $display("FAIL lw got imm=%h ld=%b wb=%0d exp 0000000f/1/4", imm_o, is_load_o, wb_reg_o);
    end
    cycle(1'b1, 32'h0078_0E02, 1'b1, 1'b0, acc);
    nvec++;
    if ({is_store_o, reg_write_o, wb_reg_o} !== {1'b1, 1'b0, 5'd0}) begin
      nerr++; $display("FAIL sw got st=%b rw=%b wb=%0d exp 1/0/0", is_store_o, reg_write_o, wb_reg_o);
    end
  endtask

  task automatic test_li();
    logic acc;
    cycle(1'b1, 32'hFFF8_002D, 1'b1, 1'b0, acc);
    nvec++;
    if ({imm_o, wb_reg_o, z_imm} !== {32'hFFFF_FFFF, 5'd2, 32'h0000_1FFF}) begin
      nerr++; $display("FAIL li got imm=%h wb=%0d zimm=%h exp ffffffff/2/00001fff", imm_o, wb_reg_o, z_imm);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] prog [12];
    logic        acc;
    int          idx, cyc;
    int unsigned c0;
    prog = '{32'h0000_4230, 32'h0078_0801, 32'h0078_0E02, 32'hFFF8_002D,
             32'h0001_2343, 32'h0005_6784, 32'h89AB_CDE5, 32'h1357_9BD6,
             32'h2468_ACE7, 32'hFEDC_BA98, 32'h0F0F_0F09, 32'hA5A5_A5AC};
    do_reset();
    c0  = n_consumed;
    idx = 0;
    cyc = 0;
    while ((idx < 12 || q.size() != 0) && cyc < 100) begin
      cycle(idx < 12, (idx < 12) ? prog[idx] : 32'h0, !(cyc >= 2 && cyc < 5), 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    nvec++;
    if ({cyc < 100, n_consumed - c0, instr_count_o} !== {1'b1, 32'd12, 32'd12}) begin
      nerr++; $display("FAIL stream cycles=%0d consumed=%0d cnt=%0d exp <100/12/12",
                       cyc, n_consumed - c0, instr_count_o);
    end
  endtask

  task automatic test_illegal_flush();
    logic acc;
    do_reset();
    cycle(1'b1, 32'h0000_000E, 1'b0, 1'b0, acc);
    nvec++;
    if ({dec_valid_o, illegal_o, illegal_count_o, is_alu_o, is_load_o, is_store_o,
         is_branch_o, is_jump_o, is_li_o, reg_write_o} !== {2'b11, 16'd1, 7'd0}) begin
      nerr++; $display("FAIL illegal got v=%b ill=%b icnt=%0d flags=%b%b%b%b%b%b%b exp 1/1/1/0000000",
                       dec_valid_o, illegal_o, illegal_count_o, is_alu_o, is_load_o, is_store_o,
                       is_branch_o, is_jump_o, is_li_o, reg_write_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h0000_4230, 1'b0, 1'b0, acc);
      nvec++;
      if (instr_ready_o !== 1'b0) begin
        nerr++; $display("FAIL halt_ready got=%b exp=0", instr_ready_o);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
    instr_valid_i = 1'b0; flush_i = 1'b0; dec_ready_i = 1'b0;
    #1;
    nvec++;
    if ({dec_valid_o, instr_ready_o, instr_count_o, illegal_count_o} !== {2'b01, 32'd1, 16'd1}) begin
      nerr++; $display("FAIL flush got v=%b rdy=%b cnt=%0d icnt=%0d exp 0/1/1/1",
                       dec_valid_o, instr_ready_o, instr_count_o, illegal_count_o);
    end
  endtask

  task automatic test_random();
    logic        acc, v, rdy, fl;
    logic [31:0] ins;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      ins = $urandom();
      ins[3:0] = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 2) != 0);
      fl  = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      cycle(v, ins, rdy, fl, acc);
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    do_reset();
    cycle(1'b1, 32'h0000_4230, 1'b0, 1'b0, acc);
    #2;
    rst_i = 1'b1;
    #1;
    nvec++;
    if ({dec_valid_o, instr_count_o, illegal_count_o} !== '0) begin
      nerr++; $display("FAIL async_reset got v=%b cnt=%0d icnt=%0d exp 0/0/0",
                       dec_valid_o, instr_count_o, illegal_count_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    instr_valid_i = 1'b0;
    m_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_li();
    test_back_to_back_stall();
    test_illegal_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
